// File: rtl/alu_shift_engine.sv
// rtl/alu_shift_engine.sv - multi-cycle nibble-serial rotate/shift executor (RLC..SRL)
module alu_shift_engine (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] din,
  input  logic       cin,
  output logic       ready,
  output logic       shift_dbh,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;

  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  state_e     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] din_q;
  logic       cin_q;
  logic [3:0] lo_nib_q;
  logic [7:0] result_q;
  logic       z_q, c_q, done_q;

  logic       si;
  logic       carry;
  logic [3:0] lo_nib;
  logic [3:0] hi_nib;
  logic       accept;

  assign accept = (state_q == S_IDLE) && start;

  // Nibble datapath: shift-in bit, carry-out and both result nibbles from the latched operand
  always_comb begin
    si     = 1'b0;
    carry  = 1'b0;
    lo_nib = 4'h0;
    hi_nib = 4'h0;
    case (op_q)
      OP_RLC:  si = din_q[7];
      OP_RRC:  si = din_q[0];
      OP_RL:   si = cin_q;
      OP_RR:   si = cin_q;
      OP_SRA:  si = din_q[7];
      default: si = 1'b0;
    endcase
    case (op_q)
      OP_RLC, OP_RL, OP_SLA: begin
        lo_nib = {din_q[2:0], si};
        hi_nib = din_q[6:3];
        carry  = din_q[7];
      end
      OP_SWAP: begin
        lo_nib = din_q[7:4];
        hi_nib = din_q[3:0];
        carry  = 1'b0;
      end
      default: begin
        lo_nib = din_q[4:1];
        hi_nib = {si, din_q[7:5]};
        carry  = din_q[0];
      end
    endcase
  end

  // Next-state logic: fixed four-cycle walk once a request is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand latch, low-nibble stage and registered result/flags/done
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      din_q    <= 8'h00;
      cin_q    <= 1'b0;
      lo_nib_q <= 4'h0;
      result_q <= 8'h00;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_HI);
      if (accept) begin
        op_q  <= op;
        din_q <= din;
        cin_q <= cin;
      end
      if (state_q == S_LO) begin
        lo_nib_q <= lo_nib;
      end
      if (state_q == S_HI) begin
        result_q <= {hi_nib, lo_nib_q};
        z_q      <= ({hi_nib, lo_nib_q} == 8'h00);
        c_q      <= carry;
      end
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign shift_dbh = (state_q == S_LO) ? carry : 1'b0;
  assign done      = done_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_n    = 1'b0;
  assign flag_h    = 1'b0;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_alu_shift_engine.sv
// tb/tb_alu_shift_engine.sv - self-checking bench for alu_shift_engine
module tb_alu_shift_engine;

  logic       clk = 1'b0;
  logic       nreset;
  logic       start;
  logic [2:0] op;
  logic [7:0] din;
  logic       cin;
  logic       ready, shift_dbh, done;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_h, flag_c;

  int errors = 0;
  int checks = 0;

  alu_shift_engine dut (
    .clk(clk), .nreset(nreset), .start(start), .op(op), .din(din), .cin(cin),
    .ready(ready), .shift_dbh(shift_dbh), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] din;
    logic       cin;
    logic [7:0] exp_res;
    logic       exp_z;
    logic       exp_c;
    logic       exp_sd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: byte-level rotate/shift arithmetic, returns {carry, result}
  function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] a, input logic c);
    logic [7:0] r;
    logic [7:0] cw;
    logic       co;
    cw = 8'(c);
    case (o)
      3'd0: begin r = (a << 1) | (a >> 7);   co = a[7]; end
      3'd1: begin r = (a >> 1) | (a << 7);   co = a[0]; end
      3'd2: begin r = (a << 1) | cw;         co = a[7]; end
      3'd3: begin r = (a >> 1) | (cw << 7);  co = a[0]; end
      3'd4: begin r = a << 1;                co = a[7]; end
      3'd5: begin r = (a >> 1) | (a & 8'h80); co = a[0]; end
      3'd6: begin r = (a << 4) | (a >> 4);   co = 1'b0; end
      default: begin r = a >> 1;             co = a[0]; end
    endcase
    return {co, r};
  endfunction

  // Issue one request from an IDLE negedge; returns at the negedge after DONE
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic c,
                       output logic [7:0] r, output logic [3:0] f,
                       output logic sd, output int lat, output logic rdy_after);
    op = o; din = a; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sd = shift_dbh;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    f = {flag_z, flag_n, flag_h, flag_c};
    @(negedge clk);
    rdy_after = ready;
  endtask

  vec_t       tbl[10];
  logic [7:0] r;
  logic [3:0] f;
  logic       sd, rdy;
  int         lat;
  logic [8:0] m;
  int         dcount;
  int         dpos[$];

  initial begin
    nreset = 1'b0; start = 1'b0; op = 3'd0; din = 8'h00; cin = 1'b0;
    tbl[0] = '{3'd2, 8'h55, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3'd2, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{3'd0, 8'h85, 1'b0, 8'h0B, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{3'd5, 8'h81, 1'b0, 8'hC0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{3'd7, 8'h81, 1'b1, 8'h40, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{3'd3, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{3'd6, 8'hF0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{3'd4, 8'h81, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{3'd1, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{3'd3, 8'h02, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {ready, done, shift_dbh, result, flag_z, flag_n, flag_h, flag_c},
          {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
    nreset = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].din, tbl[i].cin, r, f, sd, lat, rdy);
      check($sformatf("tbl%0d_result", i), r, tbl[i].exp_res);
      check($sformatf("tbl%0d_flags", i), f, {tbl[i].exp_z, 2'b00, tbl[i].exp_c});
      check($sformatf("tbl%0d_shift_dbh", i), sd, tbl[i].exp_sd);
      check($sformatf("tbl%0d_latency", i), lat, 3);
      check($sformatf("tbl%0d_ready_after", i), rdy, 1'b1);
    end

    // Exhaustive sweep against the byte-arithmetic model
    for (int o = 0; o < 8; o++)
      for (int a = 0; a < 256; a++)
        for (int c = 0; c < 2; c++) begin
          do_op(3'(o), 8'(a), 1'(c), r, f, sd, lat, rdy);
          m = model(3'(o), 8'(a), 1'(c));
          check($sformatf("sweep op%0d din%02h cin%0d", o, a, c),
                {r, f, sd, 1'b0}, {m[7:0], (m[7:0] == 8'h00), 2'b00, m[8], m[8], 1'b0});
        end

    // Random vectors
    for (int k = 0; k < 200; k++) begin
      logic [2:0] ro;
      logic [7:0] ra;
      logic       rc;
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rc = 1'($urandom);
      do_op(ro, ra, rc, r, f, sd, lat, rdy);
      m = model(ro, ra, rc);
      check($sformatf("rand op%0d din%02h cin%0d", ro, ra, rc),
            {r, f, lat[3:0]}, {m[7:0], (m[7:0] == 8'h00), 2'b00, m[8], 4'd3});
    end

    // Busy: second start with other operands during LO/HI/DONE is ignored
    op = 3'd4; din = 8'h81; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    op = 3'd7; din = 8'h7F;
    check("busy_ready_lo", ready, 1'b0);
    @(negedge clk);
    din = 8'h33;
    @(negedge clk);
    check("busy_done", done, 1'b1);
    check("busy_result", {result, flag_c}, {8'h02, 1'b1});
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("busy_extra_done", dcount, 0);
    check("busy_result_held", result, 8'h02);

    // Continuous start: accepted every 4 cycles
    op = 3'd6; din = 8'h12; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (done) dpos.push_back(k);
    end
    start = 1'b0;
    check("cont_done_count", dpos.size(), 4);
    for (int k = 0; k < dpos.size(); k++)
      check($sformatf("cont_done_pos%0d", k), dpos[k], 3 + 4 * k);
    check("cont_result", result, 8'h21);
    @(negedge clk);

    // Reset during HI aborts the request
    op = 3'd0; din = 8'hFF; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("abort_outputs", {ready, done, shift_dbh, result, flag_z, flag_n, flag_h, flag_c},
          {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
    @(negedge clk);
    nreset = 1'b1;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_result_stays", result, 8'h00);
    do_op(3'd4, 8'h81, 1'b0, r, f, sd, lat, rdy);
    check("post_reset_sla", {r, f, lat[3:0]}, {8'h02, 4'b0001, 4'd3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_shift_engine.md
# alu_shift_engine

Multi-cycle executor for the CB-prefix rotate/shift group: RLC, RRC, RL, RR, SLA, SRA, SWAP and SRL. It computes through a 4-bit nibble datapath, low nibble first and then high nibble, matching the two-phase L/H sequencing of the main ALU. It sits beside the ALU as a standalone reference producer of shift results and flags. The CPU microcode sequencer and ALU cross-check benches drive it through a start/ready/done handshake.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only when `ready`=1.
- `op` in 3: operation code. 0=RLC, 1=RRC, 2=RL, 3=RR, 4=SLA, 5=SRA, 6=SWAP, 7=SRL.
- `din` in 8: operand.
- `cin` in 1: carry flag input; used by RL and RR only.
- `ready` out 1: high in IDLE.
- `shift_dbh` out 1: bit shifted out of the operand; valid in LO state, 0 otherwise.
- `done` out 1: one-cycle pulse when `result` and flags become valid.
- `result` out 8: registered result; held until the next accepted `start`.
- `flag_z`, `flag_n`, `flag_h`, `flag_c` out 1 each: registered flags; held with `result`.

## Operation
- States: IDLE, LO, HI, DONE.
  - IDLE → LO on `start`: latch `op`, `din` and `cin`.
  - LO → HI unconditionally.
  - HI → DONE unconditionally.
  - DONE → IDLE unconditionally.
- `start` in LO, HI or DONE is ignored. Inputs are sampled only at acceptance.
- Shift-in bit `si`:
  - RLC: `din[7]`. RL: `cin`. SLA: 0.
  - RRC: `din[0]`. RR: `cin`. SRA: `din[7]`. SRL: 0.
- Left group (RLC, RL, SLA):
  - LO: low nibble = {`din[2:0]`, `si`}.
  - HI: high nibble = `din[6:3]`.
  - Carry = `din[7]`.
- Right group (RRC, RR, SRA, SRL):
  - LO: low nibble = `din[4:1]`.
  - HI: high nibble = {`si`, `din[7:5]`}.
  - Carry = `din[0]`.
- SWAP:
  - LO: low nibble = `din[7:4]`.
  - HI: high nibble = `din[3:0]`.
  - Carry = 0.
- `shift_dbh` in LO equals the carry bit for the latched op (0 for SWAP).
- The low nibble is registered at the end of LO. The full byte, flags and `done` are registered at the end of HI.
- Flags:
  - `flag_z` = (8-bit result == 0).
  - `flag_n` = 0.
  - `flag_h` = 0.
  - `flag_c` = carry as above.
- All arithmetic is a pure 8-bit bit permutation; no widening.
- Reset values: `ready`=1, `done`=0, `shift_dbh`=0, `result`=0x00, all flags 0, state IDLE.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values, and no `done` is produced for the aborted request.

## Timing
- `start` accepted at edge t → state LO during cycle t+1, HI during t+2.
- `done`=1 and new `result`/flags visible during cycle t+3 (DONE). `ready`=1 again from t+4.
- Throughput: one operation per 4 cycles. A `start` held high continuously is re-accepted at t+4.
- `ready` is low during LO, HI and DONE.
- `result` and flags change only on the HI→DONE edge or on reset. They are stable otherwise, including through IDLE.
- `start` during DONE is not queued; it must be presented again in IDLE.

## Test plan
- RL, `din`=0x55, `cin`=1: result 0xAB, Z=0, C=0, `shift_dbh`=0 in LO; `done` exactly 3 cycles after acceptance.
- RL, `din`=0x80, `cin`=0: result 0x00, Z=1, C=1, `shift_dbh`=1 in LO. Then RLC, `din`=0x85: result 0x0B, C=1.
- Right group, `din`=0x81:
  - SRA: result 0xC0, C=1.
  - SRL: result 0x40, C=1.
  - RR with `cin`=0 on `din`=0x01: result 0x00, Z=1, C=1.
- SWAP, `din`=0xF0: result 0x0F, C=0, Z=0, `shift_dbh`=0. N and H are 0 for every op in an exhaustive sweep of all 8 ops × 256 operands × both `cin` values, checked against a bit-permutation model.
- Busy handling:
  - Second `start` with a different operand during LO/HI/DONE is ignored; result reflects the first request only, and only one `done` pulse occurs.
  - Continuous `start`: accepted every 4 cycles.
- Reset handling: deassert `nreset` during HI → outputs read `ready`=1, `done`=0, result 0x00, flags 0 immediately, with no `done` afterwards. A fresh SLA on 0x81 then yields 0x02, C=1.
